rs_cmd_conditioner: RTL
=======================

Name: rs_cmd_conditioner

Overview:
- Upstream stage of the RS flip-flop. Converts two raw, bouncy push-button levels (set/reset request) into clean, single-cycle Set/Reset command pulses.
- Per channel: 2-flop synchronizer, debounce filter, rising-edge detector.
- Conflict arbiter guarantees the downstream flip-flop never sees Set=1 and Reset=1 in the same cycle (its undefined 1/1 case).

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronized level must differ from the debounced state before the debounced state changes (legal 2..2^CNT_W).
- CNT_W, 3: width of each debounce counter; must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- set_btn  in  1  raw asynchronous set request level
- reset_btn  in  1  raw asynchronous reset request level
- Set  out  1  registered one-cycle set command to RS flip-flop
- Reset  out  1  registered one-cycle reset command to RS flip-flop
- conflict  out  1  registered one-cycle flag: simultaneous requests were dropped

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset=1 at a rising edge clears every register: sync flops, debounced states, counters, edge history, Set, Reset, conflict all 0.
  - Reset mid-debounce discards partial counts.
  - A button still held after reset is treated as a new press and produces one pulse after full latency.
- Synchronizer: s1 <= btn; s2 <= s1, per channel.
- Debounce, per channel, state db and counter cnt:
  - s2 == db: cnt <= 0.
  - s2 != db and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s2 != db and cnt == DB_CYCLES-1: db <= s2; cnt <= 0.
  - db therefore changes only after s2 differs on DB_CYCLES consecutive edges.
  - A glitch shorter than that clears cnt and produces nothing.
- Edge detect: req = db & ~db_prev, where db_prev is db delayed one cycle. Release (falling db) produces no output.
- Arbiter, registered outputs:
  - Only set req: Set <= 1, others 0.
  - Only reset req: Reset <= 1, others 0.
  - Both req same cycle: Set <= 0, Reset <= 0, conflict <= 1. Both requests are dropped, not queued.
  - Otherwise all outputs <= 0.
  - Set & Reset is never 1 in any cycle.
- A held debounced level on one channel does not block a new press on the other; each press yields exactly one pulse.
- Latency:
  - btn rising before edge 1 and held stable: Set/Reset high for exactly one cycle, from edge DB_CYCLES+3 to edge DB_CYCLES+4.
  - DB_CYCLES=4: high between edges 7 and 8.
- Repeat rate: a new pulse on a channel requires db to fall (DB_CYCLES stable low) and rise again (DB_CYCLES stable high).

Test Plan:
- Reset=1 for 2 cycles with both buttons 0 -> Set=Reset=conflict=0; after release, no output for 20 cycles.
- set_btn 0->1 before edge 1, held 20 cycles (DB_CYCLES=4) -> Set=1 only between edges 7 and 8; Reset=0, conflict=0 throughout; release gives no pulse.
- reset_btn bounce pattern 1,0,1,1,0 then steady 1 -> no pulse during bounce; exactly one Reset pulse, DB_CYCLES+1 edges after steady 1 reaches s2.
- set_btn and reset_btn rise on the same cycle and are held -> conflict=1 for one cycle at edge 7; Set=Reset=0 in every cycle.
- set_btn held high, then reset_btn pressed 10 cycles later -> one Set pulse, then one Reset pulse 10 cycles after it; never overlapping.
- reset asserted 2 cycles into a set_btn debounce while the button stays held -> no pulse during reset; one Set pulse DB_CYCLES+3 edges after reset deasserts.

Source files
------------

// File: rtl/rs_cmd_conditioner_if.sv
// Button-to-command bus between the raw push-button side and the RS
// flip-flop side of the command conditioner.
interface rs_cmd_conditioner_if;
    logic set_btn;
    logic reset_btn;
    logic Set;
    logic Reset;
    logic conflict;

    // Button driver / command consumer side
    modport master (
        output set_btn,
        output reset_btn,
        input  Set,
        input  Reset,
        input  conflict
    );

    // Conditioner side
    modport slave (
        input  set_btn,
        input  reset_btn,
        output Set,
        output Reset,
        output conflict
    );
endinterface

// File: rtl/rs_cmd_conditioner.sv
// Turns two raw, bouncy push-button levels into clean one-cycle Set/Reset
// command pulses. Each channel is synchronized, debounced and edge-detected;
// a registered arbiter drops simultaneous requests so that Set and Reset are
// never high together.
module rs_cmd_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    rs_cmd_conditioner_if.slave  bus
);

    // Counter value at which the debounced state is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Channel 0 = set request, channel 1 = reset request.
    logic [1:0] btn;
    logic [1:0] req;

    assign btn = {bus.reset_btn, bus.set_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic             db_prev_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Synchronize, debounce and keep one cycle of debounced history.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    s1_reg      <= btn[gi];
                    s2_reg      <= s1_reg;
                    db_prev_reg <= db_reg;
                    if (s2_reg == db_reg) begin
                        // Any agreement restarts the stability count.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            // Only a rising debounced level is a request; release is silent.
            assign req[gi] = db_reg & ~db_prev_reg;
        end
    endgenerate

    logic set_reg;
    logic reset_reg;
    logic conflict_reg;

    // Registered arbiter: simultaneous requests are dropped and flagged.
    always_ff @(posedge clock) begin
        if (reset) begin
            set_reg      <= 1'b0;
            reset_reg    <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            set_reg      <= req[0] & ~req[1];
            reset_reg    <= req[1] & ~req[0];
            conflict_reg <= req[0] & req[1];
        end
    end

    assign bus.Set      = set_reg;
    assign bus.Reset    = reset_reg;
    assign bus.conflict = conflict_reg;

endmodule
